// File: rtl/proc_pkg.sv
// Shared processor constants, datapath types and the immediate-extension helper.
package proc_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int IMM_W    = 8;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [IMM_W-1:0]  imm_t;

    function automatic word_t extend_imm(input imm_t imm, input logic sext);
        return sext ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
                    : {{(DATA_W-IMM_W){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Operand-fetch bus: upstream fetch request, write-back port and downstream operand slot.
interface operand_fetch_stage_if;
    import proc_pkg::*;

    logic      In_Valid;
    logic      In_Ready;
    reg_addr_t Rs_Addr;
    reg_addr_t Rt_Addr;
    imm_t      Imm;
    logic      Imm_Sext;
    logic      Flush;
    logic      Wr_En;
    reg_addr_t Wr_Addr;
    word_t     Wr_Data;
    logic      Out_Valid;
    logic      Out_Ready;
    word_t     A;
    word_t     B;
    word_t     Imm_Ext;

    modport master (
        output In_Valid, Rs_Addr, Rt_Addr, Imm, Imm_Sext, Flush,
               Wr_En, Wr_Addr, Wr_Data, Out_Ready,
        input  In_Ready, Out_Valid, A, B, Imm_Ext
    );

    modport slave (
        input  In_Valid, Rs_Addr, Rt_Addr, Imm, Imm_Sext, Flush,
               Wr_En, Wr_Addr, Wr_Data, Out_Ready,
        output In_Ready, Out_Valid, A, B, Imm_Ext
    );

endinterface

// File: rtl/reg_file_16x16.sv
// 16 x 16-bit register file: one write port, two combinational read ports, R0 hardwired to zero.
module reg_file_16x16
    import proc_pkg::*;
(
    input  logic      Clk,
    input  logic      Reset,
    input  logic      wr_en,
    input  reg_addr_t wr_addr,
    input  word_t     wr_data,
    input  reg_addr_t rd_a_addr,
    input  reg_addr_t rd_b_addr,
    output word_t     rd_a_data,
    output word_t     rd_b_data
);

    word_t regs_q [NUM_REGS];
    word_t regs_d [NUM_REGS];

    // NOTE: the full default copy keeps every entry assigned on every path, so no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != '0)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // NOTE: the array is reset because the architectural state must read zero after Reset; this costs a reset net on every bit.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of block order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_a_data = (rd_a_addr == '0) ? '0 : regs_q[rd_a_addr];
    assign rd_b_data = (rd_b_addr == '0) ? '0 : regs_q[rd_b_addr];

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode->execute operand stage: register-file read with write bypass, immediate extension,
// and a single output slot behind a valid/ready handshake.
module operand_fetch_stage
    import proc_pkg::*;
(
    input logic                 Clk,
    input logic                 Reset,
    operand_fetch_stage_if.slave bus
);

    logic  out_valid_q, out_valid_d;
    word_t a_q, a_d;
    word_t b_q, b_d;
    word_t imm_ext_q, imm_ext_d;

    word_t rf_a, rf_b;
    logic  in_ready;
    logic  capture;
    logic  bypass_a, bypass_b;

    reg_file_16x16 u_reg_file (
        .Clk       (Clk),
        .Reset     (Reset),
        .wr_en     (bus.Wr_En),
        .wr_addr   (bus.Wr_Addr),
        .wr_data   (bus.Wr_Data),
        .rd_a_addr (bus.Rs_Addr),
        .rd_b_addr (bus.Rt_Addr),
        .rd_a_data (rf_a),
        .rd_b_data (rf_b)
    );

    always_comb begin
        in_ready    = !out_valid_q || bus.Out_Ready;
        capture     = bus.In_Valid && in_ready && !bus.Flush;
        bypass_a    = bus.Wr_En && (bus.Wr_Addr == bus.Rs_Addr) && (bus.Wr_Addr != '0);
        bypass_b    = bus.Wr_En && (bus.Wr_Addr == bus.Rt_Addr) && (bus.Wr_Addr != '0);

        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        imm_ext_d   = imm_ext_q;

        // Held operands move only on capture; a flush just empties the slot.
        if (capture) begin
            out_valid_d = 1'b1;
            a_d         = bypass_a ? bus.Wr_Data : rf_a;
            b_d         = bypass_b ? bus.Wr_Data : rf_b;
            imm_ext_d   = extend_imm(bus.Imm, bus.Imm_Sext);
        end else if (bus.Out_Ready || bus.Flush) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            imm_ext_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            imm_ext_q   <= imm_ext_d;
        end
    end

    assign bus.In_Ready  = in_ready;
    assign bus.Out_Valid = out_valid_q;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.Imm_Ext   = imm_ext_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed self-checking bench for operand_fetch_stage.
module tb_operand_fetch_stage;
    import proc_pkg::*;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    operand_fetch_stage_if bus ();

    operand_fetch_stage dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.In_Valid = 1'b0;
        bus.Wr_En    = 1'b0;
        bus.Flush    = 1'b0;
    endtask

    task automatic fetch(input reg_addr_t rs, input reg_addr_t rt, input imm_t imm, input logic sext);
        bus.In_Valid = 1'b1;
        bus.Rs_Addr  = rs;
        bus.Rt_Addr  = rt;
        bus.Imm      = imm;
        bus.Imm_Sext = sext;
    endtask

    task automatic write(input reg_addr_t addr, input word_t data);
        bus.Wr_En   = 1'b1;
        bus.Wr_Addr = addr;
        bus.Wr_Data = data;
    endtask

    task automatic test_reset_state();
        total++; if (bus.Out_Valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.Out_Valid); end
        total++; if (bus.A !== 16'h0000) begin bad++; $display("FAIL rst_a: got %h want 0000", bus.A); end
        total++; if (bus.B !== 16'h0000) begin bad++; $display("FAIL rst_b: got %h want 0000", bus.B); end
        total++; if (bus.Imm_Ext !== 16'h0000) begin bad++; $display("FAIL rst_imm: got %h want 0000", bus.Imm_Ext); end
        total++; if (bus.In_Ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.In_Ready); end
    endtask

    task automatic test_write_read();
        bus.Out_Ready = 1'b1;
        write(4'd3, 16'h1234);
        tick();
        idle();
        fetch(4'd3, 4'd0, 8'h00, 1'b0);
        tick();
        idle();
        total++; if (bus.Out_Valid !== 1'b1) begin bad++; $display("FAIL wr_rd_valid: got %b want 1", bus.Out_Valid); end
        total++; if (bus.A !== 16'h1234) begin bad++; $display("FAIL wr_rd_a: got %h want 1234", bus.A); end
        total++; if (bus.B !== 16'h0000) begin bad++; $display("FAIL wr_rd_b: got %h want 0000", bus.B); end
        tick();
        total++; if (bus.Out_Valid !== 1'b0) begin bad++; $display("FAIL wr_rd_drain: got %b want 0", bus.Out_Valid); end
    endtask

    task automatic test_bypass();
        write(4'd5, 16'hBEEF);
        fetch(4'd5, 4'd5, 8'h00, 1'b0);
        tick();
        idle();
        total++; if (bus.A !== 16'hBEEF) begin bad++; $display("FAIL byp_a: got %h want beef", bus.A); end
        total++; if (bus.B !== 16'hBEEF) begin bad++; $display("FAIL byp_b: got %h want beef", bus.B); end
        fetch(4'd5, 4'd3, 8'h00, 1'b0);
        tick();
        idle();
        total++; if (bus.A !== 16'hBEEF) begin bad++; $display("FAIL byp_stored_a: got %h want beef", bus.A); end
        total++; if (bus.B !== 16'h1234) begin bad++; $display("FAIL byp_stored_b: got %h want 1234", bus.B); end
        tick();
    endtask

    task automatic test_r0();
        write(4'd0, 16'hFFFF);
        tick();
        idle();
        write(4'd0, 16'hFFFF);
        fetch(4'd0, 4'd0, 8'h00, 1'b0);
        tick();
        idle();
        total++; if (bus.A !== 16'h0000) begin bad++; $display("FAIL r0_a: got %h want 0000", bus.A); end
        total++; if (bus.B !== 16'h0000) begin bad++; $display("FAIL r0_b: got %h want 0000", bus.B); end
        tick();
    endtask

    task automatic test_imm();
        fetch(4'd0, 4'd0, 8'h80, 1'b1);
        tick();
        total++; if (bus.Imm_Ext !== 16'hFF80) begin bad++; $display("FAIL imm_sext80: got %h want ff80", bus.Imm_Ext); end
        fetch(4'd0, 4'd0, 8'h80, 1'b0);
        tick();
        total++; if (bus.Imm_Ext !== 16'h0080) begin bad++; $display("FAIL imm_zext80: got %h want 0080", bus.Imm_Ext); end
        fetch(4'd0, 4'd0, 8'h7F, 1'b1);
        tick();
        idle();
        total++; if (bus.Imm_Ext !== 16'h007F) begin bad++; $display("FAIL imm_sext7f: got %h want 007f", bus.Imm_Ext); end
        tick();
    endtask

    task automatic test_stall_flush();
        bus.Out_Ready = 1'b0;
        fetch(4'd3, 4'd5, 8'h12, 1'b0);
        tick();
        total++; if (bus.Out_Valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", bus.Out_Valid); end
        total++; if (bus.In_Ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b want 0", bus.In_Ready); end
        for (int i = 0; i < 3; i++) begin
            fetch(4'd5, 4'd3, 8'hF0, 1'b1);
            bus.Wr_En = 1'b0;
            if (i == 0) write(4'd3, 16'hAAAA);
            tick();
            total++; if (bus.In_Ready !== 1'b0) begin bad++; $display("FAIL stall%0d_in_ready: got %b want 0", i, bus.In_Ready); end
            total++; if (bus.Out_Valid !== 1'b1) begin bad++; $display("FAIL stall%0d_valid: got %b want 1", i, bus.Out_Valid); end
            total++; if (bus.A !== 16'h1234) begin bad++; $display("FAIL stall%0d_a: got %h want 1234", i, bus.A); end
            total++; if (bus.B !== 16'hBEEF) begin bad++; $display("FAIL stall%0d_b: got %h want beef", i, bus.B); end
            total++; if (bus.Imm_Ext !== 16'h0012) begin bad++; $display("FAIL stall%0d_imm: got %h want 0012", i, bus.Imm_Ext); end
        end
        bus.Wr_En = 1'b0;
        bus.Flush = 1'b1;
        fetch(4'd5, 4'd5, 8'h01, 1'b0);
        write(4'd7, 16'h7777);
        tick();
        total++; if (bus.Out_Valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", bus.Out_Valid); end
        total++; if (bus.A !== 16'h1234) begin bad++; $display("FAIL flush_a_hold: got %h want 1234", bus.A); end
        bus.Wr_En = 1'b0;
        tick();
        total++; if (bus.Out_Valid !== 1'b0) begin bad++; $display("FAIL flush_prio_valid: got %b want 0", bus.Out_Valid); end
        total++; if (bus.B !== 16'hBEEF) begin bad++; $display("FAIL flush_prio_b: got %h want beef", bus.B); end
        idle();
        bus.Out_Ready = 1'b1;
        fetch(4'd7, 4'd3, 8'h00, 1'b0);
        tick();
        idle();
        total++; if (bus.A !== 16'h7777) begin bad++; $display("FAIL flush_wb_a: got %h want 7777", bus.A); end
        total++; if (bus.B !== 16'hAAAA) begin bad++; $display("FAIL stall_wb_b: got %h want aaaa", bus.B); end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.Out_Ready = 1'b1;
        fetch(4'd7, 4'd5, 8'h01, 1'b0);
        tick();
        total++; if (bus.A !== 16'h7777) begin bad++; $display("FAIL b2b0_a: got %h want 7777", bus.A); end
        total++; if (bus.B !== 16'hBEEF) begin bad++; $display("FAIL b2b0_b: got %h want beef", bus.B); end
        total++; if (bus.Imm_Ext !== 16'h0001) begin bad++; $display("FAIL b2b0_imm: got %h want 0001", bus.Imm_Ext); end
        fetch(4'd5, 4'd3, 8'hFF, 1'b1);
        tick();
        idle();
        total++; if (bus.Out_Valid !== 1'b1) begin bad++; $display("FAIL b2b1_valid: got %b want 1", bus.Out_Valid); end
        total++; if (bus.A !== 16'hBEEF) begin bad++; $display("FAIL b2b1_a: got %h want beef", bus.A); end
        total++; if (bus.B !== 16'hAAAA) begin bad++; $display("FAIL b2b1_b: got %h want aaaa", bus.B); end
        total++; if (bus.Imm_Ext !== 16'hFFFF) begin bad++; $display("FAIL b2b1_imm: got %h want ffff", bus.Imm_Ext); end
        tick();
        total++; if (bus.Out_Valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", bus.Out_Valid); end
    endtask

    task automatic test_reset();
        bus.Out_Ready = 1'b0;
        fetch(4'd3, 4'd7, 8'h80, 1'b1);
        tick();
        idle();
        total++; if (bus.Out_Valid !== 1'b1) begin bad++; $display("FAIL prerst_valid: got %b want 1", bus.Out_Valid); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.Out_Valid !== 1'b0) begin bad++; $display("FAIL async_rst_valid: got %b want 0", bus.Out_Valid); end
        total++; if (bus.A !== 16'h0000) begin bad++; $display("FAIL async_rst_a: got %h want 0000", bus.A); end
        total++; if (bus.B !== 16'h0000) begin bad++; $display("FAIL async_rst_b: got %h want 0000", bus.B); end
        total++; if (bus.Imm_Ext !== 16'h0000) begin bad++; $display("FAIL async_rst_imm: got %h want 0000", bus.Imm_Ext); end
        #1;
        rst = 1'b0;
        bus.Out_Ready = 1'b1;
        fetch(4'd3, 4'd7, 8'h00, 1'b0);
        tick();
        idle();
        total++; if (bus.Out_Valid !== 1'b1) begin bad++; $display("FAIL postrst_valid: got %b want 1", bus.Out_Valid); end
        total++; if (bus.A !== 16'h0000) begin bad++; $display("FAIL postrst_r3: got %h want 0000", bus.A); end
        total++; if (bus.B !== 16'h0000) begin bad++; $display("FAIL postrst_r7: got %h want 0000", bus.B); end
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        bus.In_Valid  = 1'b0;
        bus.Rs_Addr   = '0;
        bus.Rt_Addr   = '0;
        bus.Imm       = '0;
        bus.Imm_Sext  = 1'b0;
        bus.Flush     = 1'b0;
        bus.Wr_En     = 1'b0;
        bus.Wr_Addr   = '0;
        bus.Wr_Data   = '0;
        bus.Out_Ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        test_reset_state();
        test_write_read();
        test_bypass();
        test_r0();
        test_imm();
        test_stall_flush();
        test_back_to_back();
        test_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
